// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage fed by the ALU result.
// Runs one load or store per request against a word-wide memory with a ready
// handshake. It selects byte and halfword lanes, builds store strobes and
// replicated write data, and sign- or zero-extends load results.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, is_store, funct3  request strobe and RISC-V access code
//   addr, store_data         effective address and rs2 value
//   mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ready   memory side
//   busy, done, err, load_data                          writeback side
//
// Optional build macro: LSU_MISALIGN_TRAP_EN.
//   Defined   - a misaligned halfword or word access completes with err=1
//               and makes no memory access.
//   Undefined - the low address bits are forced to natural alignment and
//               the access runs normally.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] load_data
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state_q;
  logic                is_store_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                mem_req_q, mem_we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, load_data_q;
  logic [3:0]          mem_wstrb_q;

  // Decode of the incoming request, used only in the IDLE->REQ/DONE step.
  logic                legal, bad;
  logic [1:0]          off_d;
  logic [3:0]          wstrb_d;
  logic [DATA_W-1:0]   wdata_d;

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !is_store;  // LBU/LHU have no store form
      default:                legal = 1'b0;
    endcase
    off_d = addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    bad = !legal ||
          (funct3[1:0] == 2'b01 && addr[0]) ||
          (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    bad = !legal;
    // Force natural alignment instead of trapping.
    if (funct3[1:0] == 2'b01)      off_d = {addr[1], 1'b0};
    else if (funct3[1:0] == 2'b10) off_d = 2'b00;
`endif
    wstrb_d = 4'b0000;
    wdata_d = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << off_d;
          wdata_d = {4{store_data[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << {off_d[1], 1'b0};
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = store_data;
        end
      endcase
    end
  end

  // Lane select and extension of the returned word, from the latched request.
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    byte_v = mem_rdata[{off_q, 3'b000} +: 8];
    half_v = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, byte_v};
      3'b001:  ld_ext = {{(DATA_W-16){half_v[15]}}, half_v};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, half_v};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            f3_q       <= funct3;
            off_q      <= off_d;
            busy_q     <= 1'b1;
            if (bad) begin
              // Rejected request: report straight away, memory untouched.
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wstrb_q <= wstrb_d;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            if (!is_store_q) load_data_q <= ld_ext;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;

endmodule
